// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer for a small asynchronous-read instruction
// memory. It owns the fetch PC and drives the word address to the imem. Each
// returned word is captured, together with its PC, into a small FIFO. Decode
// drains that FIFO over a valid/ready handshake. A redirect loads a new fetch
// PC and flushes the FIFO.
//
// Ports
//   clk               rising-edge clock
//   reset_n           asynchronous, active-low reset (release is synchronous
//                     to the driving logic)
//   imem_addr         word address to imem, taken from fetch_pc[ADDR_W+1:2]
//   imem_rdata        combinational read data returned by imem
//   redirect_valid    load redirect_pc into the fetch PC and flush the queue
//   redirect_pc       byte target PC; the low two bits are dropped
//   out_valid         queue head is valid
//   out_ready         decode accepts the head this cycle
//   out_instr         head instruction, 0 when the queue is empty
//   out_pc            byte PC of the head instruction, 0 when the queue is empty
//   q_count           number of occupied queue entries
//   redirect_misalign 1-cycle pulse after a redirect whose pc[1:0] != 0
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 6,
  parameter int          DATA_W   = 32,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [DATA_W-1:0]            imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [31:0]                  out_pc,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  output logic                         redirect_misalign
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  // Architectural state
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             misalign_reg, misalign_next;

  // Queue storage: PC and instruction per entry, no reset needed because
  // the head is masked by out_valid.
  logic [31:0]       pc_mem    [QDEPTH];
  logic [DATA_W-1:0] instr_mem [QDEPTH];

  logic full;
  logic pop;
  logic push;

  assign full = (count_reg == CNT_W'(QDEPTH));
  assign pop  = out_valid & out_ready;
  // The imem never stalls, so a word is captured whenever there is room,
  // including a full queue whose head leaves in the same cycle.
  assign push = ~redirect_valid & (~full | pop);

  // Next-state logic
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    misalign_next = 1'b0;

    if (redirect_valid) begin
      // A same-cycle handshake is still taken by decode; the flush simply
      // discards whatever remains.
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
      misalign_next = |redirect_pc[1:0];
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      misalign_reg <= misalign_next;
    end
  end

  // Per-entry write ports
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          pc_mem[gi]    <= fetch_pc_reg;
          instr_mem[gi] <= imem_rdata;
        end
      end
    end
  endgenerate

  // Outputs
  assign imem_addr         = fetch_pc_reg[ADDR_W+1:2];
  assign out_valid         = (count_reg != '0);
  assign out_pc            = out_valid ? pc_mem[rd_ptr_reg] : 32'd0;
  assign out_instr         = out_valid ? instr_mem[rd_ptr_reg] : '0;
  assign q_count           = count_reg;
  assign redirect_misalign = misalign_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Bench for imem_fetch_ctrl. It models an imem preloaded with
// RAM[i] = 32'hA000_0000 + i. Streaming behaviour is checked against a
// scoreboard of expected PCs. A per-cycle vector table covers stall,
// redirect, misalign and wrap, and a hand-written sequence covers an
// asynchronous reset with a full queue.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  q_count;
  logic        redirect_misalign;

  int n_vec;
  int n_err;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [1:0]  exp_count;
    logic        exp_mis;
    logic [5:0]  exp_addr;
  } vec_t;

  vec_t vecs[21];

  imem_fetch_ctrl #(
    .ADDR_W  (6),
    .DATA_W  (32),
    .QDEPTH  (2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .q_count          (q_count),
    .redirect_misalign(redirect_misalign)
  );

  // Asynchronous-read instruction memory model
  assign imem_rdata = 32'hA000_0000 + {26'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 + {26'd0, pc[7:2]};
  endfunction

  function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [1:0] cnt, input logic mis, input logic [5:0] addr);
    vec_t r;
    r.ready = ready; r.rv = rv; r.rpc = rpc; r.exp_valid = v; r.exp_pc = pc;
    r.exp_instr = ins; r.exp_count = cnt; r.exp_mis = mis; r.exp_addr = addr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reset asserted across two edges; released 2 time units after a rising
  // edge, so the next negedge precedes the first post-reset edge.
  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic push_expected(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(start + 32'(4 * k));
  endtask

  // Runs a fixed number of cycles; every handshake is scored against the
  // expected-PC queue. With no_bubble set, out_valid must be high from the
  // second cycle on.
  task automatic run_stream(input int cycles, input bit rand_ready, input bit no_bubble);
    logic [31:0] e;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (no_bubble && c > 0) check("no_bubble", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pop", out_pc, 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          check("stream_pc", out_pc, e);
          check("stream_instr", out_instr, instr_of(e));
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_mis", 32'(redirect_misalign), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);

    // Continuous stream with out_ready held high
    do_reset();
    sb_q.delete();
    push_expected(32'd0, 40);
    run_stream(41, 1'b0, 1'b1);
    check("stream_drained", 32'(sb_q.size()), 32'd0);

    // Random back-pressure: order preserved with no loss or duplication
    do_reset();
    sb_q.delete();
    push_expected(32'd0, 100);
    run_stream(90, 1'b1, 1'b0);

    // Per-cycle vector table: stall, redirect, misalign, wraps
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 6'h00);
    vecs[1]  = mk(0, 0, 32'h0,        1, 32'h0,        32'hA0000000, 2'd1, 0, 6'h01);
    vecs[2]  = mk(0, 0, 32'h0,        1, 32'h0,        32'hA0000000, 2'd2, 0, 6'h02);
    vecs[3]  = mk(0, 0, 32'h0,        1, 32'h0,        32'hA0000000, 2'd2, 0, 6'h02);
    vecs[4]  = mk(0, 0, 32'h0,        1, 32'h0,        32'hA0000000, 2'd2, 0, 6'h02);
    vecs[5]  = mk(1, 0, 32'h0,        1, 32'h0,        32'hA0000000, 2'd2, 0, 6'h02);
    vecs[6]  = mk(1, 0, 32'h0,        1, 32'h4,        32'hA0000001, 2'd2, 0, 6'h03);
    vecs[7]  = mk(0, 0, 32'h0,        1, 32'h8,        32'hA0000002, 2'd2, 0, 6'h04);
    vecs[8]  = mk(0, 1, 32'h40,       1, 32'h8,        32'hA0000002, 2'd2, 0, 6'h04);
    vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 6'h10);
    vecs[10] = mk(1, 0, 32'h0,        1, 32'h40,       32'hA0000010, 2'd1, 0, 6'h11);
    vecs[11] = mk(1, 1, 32'h46,       1, 32'h44,       32'hA0000011, 2'd1, 0, 6'h12);
    vecs[12] = mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        2'd0, 1, 6'h11);
    vecs[13] = mk(1, 0, 32'h0,        1, 32'h44,       32'hA0000011, 2'd1, 0, 6'h12);
    vecs[14] = mk(1, 1, 32'hFC,       1, 32'h48,       32'hA0000012, 2'd1, 0, 6'h13);
    vecs[15] = mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 6'h3F);
    vecs[16] = mk(1, 0, 32'h0,        1, 32'hFC,       32'hA000003F, 2'd1, 0, 6'h00);
    vecs[17] = mk(1, 1, 32'hFFFFFFFC, 1, 32'h100,      32'hA0000000, 2'd1, 0, 6'h01);
    vecs[18] = mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 6'h3F);
    vecs[19] = mk(1, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hA000003F, 2'd1, 0, 6'h00);
    vecs[20] = mk(1, 0, 32'h0,        1, 32'h0,        32'hA0000000, 2'd1, 0, 6'h01);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
      check($sformatf("v%0d_count", i), 32'(q_count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_mis", i), 32'(redirect_misalign), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
    end
    @(negedge clk);
    redirect_valid = 1'b0;

    // Asynchronous reset with a full queue, away from any clock edge
    do_reset();
    repeat (3) begin
      @(negedge clk);
      out_ready = 1'b0;
    end
    #1 check("pre_arst_count", 32'(q_count), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(q_count), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    sb_q.delete();
    push_expected(32'd0, 10);
    run_stream(11, 1'b0, 1'b1);
    check("restart_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
